// File: rtl/noise_gate_pkg.sv
// Shared types and constants for the noise gate: state encoding, Q1.15/Q2.15 widths, unity gain.
package noise_gate_pkg;

   localparam int SAMPLE_W = 16;
   localparam int GAIN_W   = 17;

   localparam logic [GAIN_W-1:0] GAIN_UNITY = 17'h08000;

   typedef enum logic [2:0] {
      CLOSED  = 3'd0,
      ATTACK  = 3'd1,
      OPEN    = 3'd2,
      HOLD    = 3'd3,
      RELEASE = 3'd4
   } gate_state_t;

endpackage

// File: rtl/gate_gain_mult.sv
// Registered Q1.15 sample x Q2.15 gain multiply; one-cycle latency, valid travels with the product.
module gate_gain_mult
   import noise_gate_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       x_valid,
   input  logic signed [SAMPLE_W-1:0] x_in,
   input  logic        [GAIN_W-1:0]   gain,
   output logic                       y_valid,
   output logic signed [SAMPLE_W-1:0] y_out
);

   localparam int PROD_W = 2 * GAIN_W;

   logic signed [GAIN_W-1:0] x_ext;
   logic signed [GAIN_W-1:0] g_ext;
   logic signed [PROD_W-1:0] prod;
   logic                     unused_prod_bits;

   // Gain never exceeds 0x8000, so its MSB is zero and the signed view is exact.
   assign x_ext = {x_in[SAMPLE_W-1], x_in};
   assign g_ext = signed'(gain);
   assign prod  = PROD_W'(x_ext) * PROD_W'(g_ext);

   assign unused_prod_bits = ^{prod[PROD_W-1:31], prod[14:0]};

   function automatic logic signed [SAMPLE_W-1:0] q15_scale(input logic signed [PROD_W-1:0] p);
      return p[30:15];
   endfunction

   // ---- stage p0 -> output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         y_valid <= 1'b0;
         y_out   <= '0;
      end else begin
         y_valid <= x_valid;
         if (x_valid) y_out <= q15_scale(prod);
      end
   end

endmodule

// File: rtl/noise_gate.sv
// Hysteretic noise gate: level-driven attack/hold/release gain FSM feeding a registered gain multiply.
module noise_gate
   import noise_gate_pkg::*;
#(
   parameter int ATTACK_STEP  = 512,
   parameter int RELEASE_STEP = 32,
   parameter int HOLD_SAMPLES = 4800,
   parameter int HOLD_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       x_valid,
   input  logic signed [SAMPLE_W-1:0] x_in,
   input  logic        [SAMPLE_W-1:0] rms_in,
   input  logic        [SAMPLE_W-1:0] thr_open,
   input  logic        [SAMPLE_W-1:0] thr_close,
   output logic                       y_valid,
   output logic signed [SAMPLE_W-1:0] y_out,
   output logic                       gate_open,
   output logic        [GAIN_W-1:0]   gain_out
);

   localparam logic [GAIN_W-1:0] A_STEP    = GAIN_W'(ATTACK_STEP);
   localparam logic [GAIN_W-1:0] R_STEP    = GAIN_W'(RELEASE_STEP);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLD_SAMPLES > 0) ? HOLD_SAMPLES - 1 : 0);

   gate_state_t         state, state_nxt;
   logic [GAIN_W-1:0]   gain, gain_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic                above_open, below_close;

   function automatic logic [GAIN_W-1:0] ramp_up(input logic [GAIN_W-1:0] g);
      logic [GAIN_W:0] s;
      s = {1'b0, g} + {1'b0, A_STEP};
      return (s >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : s[GAIN_W-1:0];
   endfunction

   function automatic logic [GAIN_W-1:0] ramp_down(input logic [GAIN_W-1:0] g);
      return (g <= R_STEP) ? '0 : g - R_STEP;
   endfunction

   assign above_open  = (rms_in >= thr_open);
   assign below_close = (rms_in <  thr_close);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLOSED;
         gain     <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gain     <= gain_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Transitions into ATTACK or RELEASE leave the gain untouched on that edge.
   always_comb begin
      state_nxt    = state;
      gain_nxt     = gain;
      hold_cnt_nxt = hold_cnt;
      if (x_valid) begin
         case (state)
            CLOSED: begin
               gain_nxt = '0;
               if (above_open) state_nxt = ATTACK;
            end
            ATTACK: begin
               if (below_close) begin
                  state_nxt = RELEASE;
               end else begin
                  gain_nxt = ramp_up(gain);
                  if (ramp_up(gain) == GAIN_UNITY) state_nxt = OPEN;
               end
            end
            OPEN: begin
               gain_nxt = GAIN_UNITY;
               if (below_close) begin
                  if (HOLD_SAMPLES == 0) begin
                     state_nxt = RELEASE;
                  end else begin
                     state_nxt    = HOLD;
                     hold_cnt_nxt = HOLD_INIT;
                  end
               end
            end
            HOLD: begin
               gain_nxt = GAIN_UNITY;
               if (above_open)          state_nxt    = OPEN;
               else if (hold_cnt == '0) state_nxt    = RELEASE;
               else                     hold_cnt_nxt = hold_cnt - 1'b1;
            end
            RELEASE: begin
               if (above_open) begin
                  state_nxt = ATTACK;
               end else begin
                  gain_nxt = ramp_down(gain);
                  if (ramp_down(gain) == '0) state_nxt = CLOSED;
               end
            end
            default: begin
               state_nxt = CLOSED;
               gain_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      gate_open = (state == ATTACK) || (state == OPEN) || (state == HOLD);
   end

   assign gain_out = gain;

   gate_gain_mult u_mult (
      .clk     (clk),
      .rst     (rst),
      .x_valid (x_valid),
      .x_in    (x_in),
      .gain    (gain),
      .y_valid (y_valid),
      .y_out   (y_out)
   );

endmodule
